// File: rtl/elevator_pkg.sv
// Shared Elevator definitions: floor count, request vector widths, lamp
// levels, direction codes and hall bit-index helpers.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 7;
  localparam int unsigned HALL_W     = 14;
  localparam int unsigned CAB_W      = 9;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    UP     = 2'b10,
    DOWN   = 2'b01,
    UPDOWN = 2'b11
  } direction_t;

  // Floor-1 DOWN and floor-7 UP do not exist.
  localparam logic [HALL_W-1:0] HALL_INVALID_MASK = 14'h2001;

  function automatic int unsigned hallUpIdx(input int unsigned floorNum);
    return 2 * floorNum - 1;
  endfunction

  function automatic int unsigned hallDownIdx(input int unsigned floorNum);
    return 2 * floorNum - 2;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debounces one raw pushbutton and reports a one-cycle press on each
// accepted 0->1 transition.
//   clk, reset   clock; synchronous active-low reset
//   raw          raw pushbutton level
//   stable       debounced level
//   press        one-cycle pulse, registered with the 0->1 change of stable
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] count;
  // Presses are withheld until the button has been seen released, so a
  // button held through reset does not fire when it debounces high.
  logic armed;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stable <= 1'b0;
      press  <= 1'b0;
      count  <= '0;
      armed  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw == stable) begin
        count <= '0;
        if (!raw) armed <= 1'b1;
      end else if (count == CNT_MAX) begin
        stable <= raw;
        count  <= '0;
        press  <= raw & armed;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/call_panel.sv
// Elevator call panel: debounces hall and cabin buttons, latches presses as
// pending requests, retires them once the Elevator reports them serviced,
// and drives the panel lamps.
//   clk, reset            clock; synchronous active-low reset
//   rawHall[13:0]         raw hall buttons (floor f: UP=2f-1, DOWN=2f-2)
//   rawCabin[9:1]         raw cabin buttons (1..7 floors, 8 open, 9 close)
//   nextFloorButton       Elevator hall feedback (1 = still pending)
//   nextInternalButton    Elevator cabin feedback [9:1]
//   floorButton           latched hall requests
//   internalButton        latched cabin requests [9:1]
//   hallLamp, cabinLamp   indicator lamps
// Optional: CALL_PANEL_LAMP_BLINK_EN blinks lamps of requests not yet
// acknowledged by the Elevator.
module call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned BLINK_PERIOD    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [HALL_W-1:0] rawHall,
  input  logic [CAB_W:1]    rawCabin,
  input  logic [HALL_W-1:0] nextFloorButton,
  input  logic [CAB_W:1]    nextInternalButton,
  output logic [HALL_W-1:0] floorButton,
  output logic [CAB_W:1]    internalButton,
  output logic [HALL_W-1:0] hallLamp,
  output logic [CAB_W:1]    cabinLamp
);

  localparam int unsigned REQ_W = HALL_W + CAB_W;

  // Encoding: bit0 = pending, bit1 = seen.
  typedef enum logic [1:0] {
    REQ_IDLE    = 2'b00,
    REQ_PENDING = 2'b01,
    REQ_SEEN    = 2'b11
  } reqState_t;

  logic [REQ_W-1:0] rawVec;
  logic [REQ_W-1:0] stableVec;
  logic [REQ_W-1:0] pressVec;
  logic [REQ_W-1:0] fbVec;
  logic [REQ_W-1:0] pendingVec;
  logic [REQ_W-1:0] seenVec;
  logic [REQ_W-1:0] lampVec;

  reqState_t state     [REQ_W];
  reqState_t stateNext [REQ_W];

  // Hall bits occupy [13:0], cabin bits [22:14]; nonexistent hall calls are forced low.
  assign rawVec = {rawCabin, rawHall & ~HALL_INVALID_MASK};
  assign fbVec  = {nextInternalButton, nextFloorButton};

  for (genvar i = 0; i < REQ_W; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (rawVec[i]),
      .stable(stableVec[i]),
      .press (pressVec[i])
    );
  end

  // Request state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REQ_W; i++) state[i] <= REQ_IDLE;
    end else begin
      for (int i = 0; i < REQ_W; i++) state[i] <= stateNext[i];
    end
  end

  // Request next-state: latch on press, acknowledge on feedback high,
  // retire on feedback low; a press at retirement re-requests.
  always_comb begin
    pendingVec = '0;
    seenVec    = '0;
    for (int i = 0; i < REQ_W; i++) begin
      stateNext[i]  = state[i];
      pendingVec[i] = (state[i] == REQ_PENDING) || (state[i] == REQ_SEEN);
      seenVec[i]    = (state[i] == REQ_SEEN);
      case (state[i])
        REQ_IDLE:    if (pressVec[i]) stateNext[i] = REQ_PENDING;
        REQ_PENDING: if (fbVec[i])    stateNext[i] = REQ_SEEN;
        REQ_SEEN:    if (!fbVec[i])   stateNext[i] = pressVec[i] ? REQ_PENDING : REQ_IDLE;
        default:                      stateNext[i] = REQ_IDLE;
      endcase
    end
  end

`ifdef CALL_PANEL_LAMP_BLINK_EN
  localparam int unsigned BLINK_W = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  logic [BLINK_W-1:0] blinkCount;
  logic               blinkPhase;

  // Free-running blink phase, starting on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blinkCount <= '0;
      blinkPhase <= ON;
    end else if (blinkCount == BLINK_W'(BLINK_PERIOD - 1)) begin
      blinkCount <= '0;
      blinkPhase <= ~blinkPhase;
    end else begin
      blinkCount <= blinkCount + BLINK_W'(1);
    end
  end

  assign lampVec = seenVec | (pendingVec & {REQ_W{blinkPhase}});

  logic unusedStable;
  assign unusedStable = ^stableVec;
`else
  assign lampVec = pendingVec;

  logic unusedSignals;
  assign unusedSignals = (^stableVec) ^ (^seenVec) ^ (BLINK_PERIOD != 0);
`endif

  assign floorButton    = pendingVec[HALL_W-1:0] & ~HALL_INVALID_MASK;
  assign internalButton = pendingVec[REQ_W-1:HALL_W];
  assign hallLamp       = lampVec[HALL_W-1:0] & ~HALL_INVALID_MASK;
  assign cabinLamp      = lampVec[REQ_W-1:HALL_W];

endmodule

// File: tb/tb_call_panel.sv
// Directed self-checking bench for call_panel with a scoreboard of expected
// pending/seen request vectors.
module tb_call_panel;
  import elevator_pkg::*;

  localparam int unsigned DC    = 16;
  localparam int unsigned BP    = 8;
  localparam int unsigned REQ_W = 23;

  logic              clk;
  logic              reset;
  logic [13:0]       rawHall;
  logic [9:1]        rawCabin;
  logic [13:0]       nextFloorButton;
  logic [9:1]        nextInternalButton;
  logic [13:0]       floorButton;
  logic [9:1]        internalButton;
  logic [13:0]       hallLamp;
  logic [9:1]        cabinLamp;

  call_panel #(
    .DEBOUNCE_CYCLES(DC),
    .BLINK_PERIOD   (BP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .rawHall           (rawHall),
    .rawCabin          (rawCabin),
    .nextFloorButton   (nextFloorButton),
    .nextInternalButton(nextInternalButton),
    .floorButton       (floorButton),
    .internalButton    (internalButton),
    .hallLamp          (hallLamp),
    .cabinLamp         (cabinLamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic [REQ_W-1:0] pend;
    logic [REQ_W-1:0] seen;
  } exp_t;

  exp_t sbq[$];
  int   passCount  = 0;
  int   checkCount = 0;
  int   failCount  = 0;

`ifdef CALL_PANEL_LAMP_BLINK_EN
  int unsigned mCnt;
  logic        mPhase;
  always @(posedge clk) begin
    if (!reset) begin
      mCnt   <= 0;
      mPhase <= 1'b1;
    end else if (mCnt == BP - 1) begin
      mCnt   <= 0;
      mPhase <= ~mPhase;
    end else begin
      mCnt <= mCnt + 1;
    end
  end
`endif

  function automatic logic [REQ_W-1:0] cab(input int c);
    logic [REQ_W-1:0] one;
    one = 1;
    return one << (13 + c);
  endfunction

  function automatic logic [REQ_W-1:0] hall(input int unsigned b);
    logic [REQ_W-1:0] one;
    one = 1;
    return one << b;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input string tag, input logic [REQ_W-1:0] p, input logic [REQ_W-1:0] s);
    exp_t e;
    e.tag  = tag;
    e.pend = p;
    e.seen = s;
    sbq.push_back(e);
  endtask

  task automatic checkOut();
    exp_t             e;
    logic [REQ_W-1:0] obsReq;
    logic [REQ_W-1:0] obsLamp;
    logic [REQ_W-1:0] expLamp;
    if (sbq.size() == 0) begin
      checkCount++;
      failCount++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e       = sbq.pop_front();
    obsReq  = {internalButton, floorButton};
    obsLamp = {cabinLamp, hallLamp};
`ifdef CALL_PANEL_LAMP_BLINK_EN
    expLamp = e.seen | (e.pend & {REQ_W{mPhase}});
`else
    expLamp = e.pend;
`endif
    checkCount++;
    assert (obsReq === e.pend) passCount++;
    else begin
      failCount++;
      $error("FAIL %s_req observed=%h expected=%h", e.tag, obsReq, e.pend);
    end
    checkCount++;
    assert (obsLamp === expLamp) passCount++;
    else begin
      failCount++;
      $error("FAIL %s_lamp observed=%h expected=%h", e.tag, obsLamp, expLamp);
    end
  endtask

  initial begin
    logic [REQ_W-1:0] hallDn2;
    logic [REQ_W-1:0] hallUp4;
    hallDn2 = hall(hallDownIdx(2));
    hallUp4 = hall(hallUpIdx(4));

    reset              = 1'b0;
    rawHall            = '0;
    rawCabin           = '0;
    nextFloorButton    = '0;
    nextInternalButton = '0;
    tick(3);
    pushExp("reset", '0, '0);
    checkOut();
    reset = 1'b1;
    tick(1);

    // Hall floor-2 DOWN: latches DC+1 cycles after the raw edge.
    rawHall[hallDownIdx(2)] = 1'b1;
    tick(DC);
    pushExp("deb_early", '0, '0);
    checkOut();
    tick(1);
    pushExp("deb_latch", hallDn2, '0);
    checkOut();
    rawHall = '0;
    nextFloorButton[hallDownIdx(2)] = 1'b1;
    tick(1);
    pushExp("hall_seen", hallDn2, hallDn2);
    checkOut();
    nextFloorButton = '0;
    tick(1);
    pushExp("hall_retire", '0, '0);
    checkOut();

    // Short pulse never latches.
    rawCabin[5] = 1'b1;
    tick(10);
    rawCabin[5] = 1'b0;
    tick(30);
    pushExp("glitch", '0, '0);
    checkOut();

    // Cabin 3: feedback low alone never retires.
    rawCabin[3] = 1'b1;
    tick(DC + 1);
    pushExp("cab3_latch", cab(3), '0);
    checkOut();
    rawCabin[3] = 1'b0;
    tick(50);
    pushExp("cab3_hold", cab(3), '0);
    checkOut();
    nextInternalButton[3] = 1'b1;
    tick(1);
    pushExp("cab3_seen", cab(3), cab(3));
    checkOut();
    tick(3);
    nextInternalButton[3] = 1'b0;
    tick(1);
    pushExp("cab3_retire", '0, '0);
    checkOut();

    // Re-press coinciding with retirement returns to PENDING.
    rawCabin[3] = 1'b1;
    tick(DC + 1);
    pushExp("cab3_relatch", cab(3), '0);
    checkOut();
    nextInternalButton[3] = 1'b1;
    tick(1);
    rawCabin[3] = 1'b0;
    tick(20);
    pushExp("cab3_seen_hold", cab(3), cab(3));
    checkOut();
    rawCabin[3] = 1'b1;
    tick(DC);
    nextInternalButton[3] = 1'b0;
    tick(1);
    pushExp("coincide", cab(3), '0);
    checkOut();
    tick(1);
    pushExp("coincide_hold", cab(3), '0);
    checkOut();
    rawCabin[3] = 1'b0;
    nextInternalButton[3] = 1'b1;
    tick(1);
    nextInternalButton[3] = 1'b0;
    tick(1);
    pushExp("cleanup", '0, '0);
    checkOut();

    // All hall buttons plus cabin 1 and door-open; invalid bits stay low.
    rawHall     = 14'h3FFF;
    rawCabin[1] = 1'b1;
    rawCabin[8] = 1'b1;
    tick(DC + 1);
    pushExp("all_hall", {9'b0, 14'h1FFE} | cab(1) | cab(8), '0);
    checkOut();

    // Mid-operation reset; held buttons must not re-latch.
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    pushExp("reset_mid", '0, '0);
    checkOut();
    tick(40);
    pushExp("held_no_relatch", '0, '0);
    checkOut();
    rawHall  = '0;
    rawCabin = '0;
    tick(20);
    pushExp("released", '0, '0);
    checkOut();
    rawHall[hallUpIdx(4)] = 1'b1;
    tick(DC + 1);
    pushExp("relatch", hallUp4, '0);
    checkOut();
    rawHall = '0;

    // Lamp behaviour across blink periods, pending then acknowledged.
    for (int i = 0; i < 20; i++) begin
      tick(1);
      pushExp("lamp_pending", hallUp4, '0);
      checkOut();
    end
    nextFloorButton[hallUpIdx(4)] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pushExp("lamp_seen", hallUp4, hallUp4);
      checkOut();
    end
    nextFloorButton = '0;
    tick(1);
    pushExp("final_retire", '0, '0);
    checkOut();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/call_panel.md
Name: call_panel

Overview:
- Front end of the Elevator: the side that produces its request inputs and consumes its request-feedback outputs.
- Debounces the raw hall and cabin pushbuttons and latches each debounced press as a pending request.
- Drives the registered request vectors the Elevator samples on `floorButton`/`internalButton`.
- Retires a request only after the Elevator reports it serviced on `nextFloorButton`/`nextInternalButton`; drives the panel lamps.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples before a raw level is accepted; must be ≥2.
- BLINK_PERIOD, 8: half-period in cycles of the lamp blink (only used with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  active-low; acts synchronously on posedge clk only
- rawHall  in  14  raw hall pushbuttons; floor f uses bits [2f-1:2f-2], upper bit = UP, lower bit = DOWN
- rawCabin  in  9  raw cabin pushbuttons [9:1]; bits 1..7 = floors, 8 = door-open, 9 = door-close
- nextFloorButton  in  14  Elevator hall feedback; 1 = still pending inside Elevator
- nextInternalButton  in  9  Elevator cabin feedback [9:1]
- floorButton  out  14  latched hall requests to Elevator
- internalButton  out  9  latched cabin requests to Elevator [9:1]
- hallLamp  out  14  hall indicator lamps
- cabinLamp  out  9  cabin indicator lamps [9:1]

Behaviour:
- Reset (reset==0 at posedge clk): all outputs 0; all debounce counters, stable levels, pending and seen flags 0.
- Invalid bits: floor-1 DOWN (bit 0) and floor-7 UP (bit 13) are tied to 0 in every vector; raw input on them is ignored.
- Debounce, per input:
  - Keep a stable level and a counter.
  - Raw ≠ stable: counter increments.
  - Raw == stable: counter clears.
  - Counter reaching DEBOUNCE_CYCLES-1 while raw ≠ stable: stable takes raw, counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Press event: a 0→1 transition of stable, lasting one cycle. Release events are ignored.
- Per-bit request state machine:
  - IDLE (pending=0): on a press event → PENDING.
  - PENDING (pending=1, seen=0): when feedback bit==1 → SEEN.
  - SEEN (pending=1, seen=1): when feedback bit==0 → IDLE (retired).
  - While in PENDING, feedback==0 never retires the request.
- Simultaneous events: a press event in the same cycle as retirement leaves the bit in PENDING with seen=0 (re-request wins).
- A press event in PENDING or SEEN is absorbed; no state change.
- Output `floorButton`/`internalButton` = pending bit, registered; latency is press event + 1 cycle.
- Raw assertion to output is DEBOUNCE_CYCLES+1 cycles.
- Cabin bits 8/9 (door open/close) follow the same machine; the Elevator's Door stage clears them.
- Lamps = pending bits.
- Reset mid-operation discards all pending requests. A button held through reset produces no press until it is released and debounced again.

Optional Feature:
- Macro: CALL_PANEL_LAMP_BLINK_EN.
- Defined:
  - A free-running counter toggles a blink phase every BLINK_PERIOD cycles; it resets to 0 with phase on.
  - Lamps in PENDING (seen=0) show the blink phase.
  - Lamps in SEEN are steady on.
  - Lamps in IDLE are off.
- Undefined: lamp = pending; no blink counter is synthesized.

Decomposition:
- Shared package elevator_pkg:
  - NUM_FLOORS=7, HALL_W=14, CAB_W=9.
  - ON/OFF.
  - Direction codes STOP=00, UP=10, DOWN=01, UPDOWN=11.
  - Hall bit-index helpers: up index 2f-1, down index 2f-2.
  - Invalid-bit mask 14'h2001.
- Sub-module button_debouncer: parameter DEBOUNCE_CYCLES, ports clk/reset/raw/stable/press. Instantiated 23 times via generate.
- The request state machine stays inline in call_panel.

Test Plan:
- Reset, then rawHall[2]=1 held 20 cycles with DEBOUNCE_CYCLES=16 → floorButton[2]=1 at cycle 17 after the raw edge; hallLamp[2]=1.
- rawCabin[5] pulsed 10 cycles → internalButton stays 0 forever.
- Latched internalButton[3]=1; nextInternalButton[3] held 0 for 50 cycles → still 1. Then feedback 1 for 4 cycles, then 0 → internalButton[3]=0 on the next cycle.
- Request in SEEN; debounced press event coincides with feedback 1→0 → internalButton stays 1 and the bit returns to PENDING (seen=0).
- rawHall=14'h3FFF held → floorButton=14'h1FFE; bits 0 and 13 stay 0.
- Hall and cabin requests pending, reset=0 for 1 cycle → all outputs 0 the next cycle. Buttons still held → no re-latch until release plus a new press.
- With CALL_PANEL_LAMP_BLINK_EN and BLINK_PERIOD=8: pending unseen lamp toggles every 8 cycles; after feedback=1 it stays steady on.
